// File: rtl/remote_comm.sv
// Host-side command initiator: sends a 16-bit command as two UART bytes (high first)
// and waits for a one-byte reply with a timeout. Includes the 8N1 UART it drives.

module UART #(
  parameter int BAUD_DIV = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       rx_rdy,
  input  logic       clr_rx_rdy,
  output logic [7:0] rx_data
);

  localparam int BW = $clog2(BAUD_DIV + 1);

  logic [9:0]    r_tx_shft;
  logic [BW-1:0] r_tx_baud;
  logic [3:0]    r_tx_bits;
  logic          r_tx_busy;
  logic          r_tx_done;

  logic          r_rx_s1;
  logic          r_rx_s2;
  logic          r_rx_busy;
  logic [BW-1:0] r_rx_baud;
  logic [3:0]    r_rx_bits;
  logic [7:0]    r_rx_shft;
  logic          r_rx_rdy;

  // Transmitter: start bit, 8 data bits LSB first, stop bit; done is a level cleared by trmt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shft <= '1;
      r_tx_baud <= '0;
      r_tx_bits <= '0;
      r_tx_busy <= 1'b0;
      r_tx_done <= 1'b0;
    end else if (trmt) begin
      r_tx_shft <= {1'b1, tx_data, 1'b0};
      r_tx_baud <= '0;
      r_tx_bits <= '0;
      r_tx_busy <= 1'b1;
      r_tx_done <= 1'b0;
    end else if (r_tx_busy) begin
      if (r_tx_baud == BW'(BAUD_DIV - 1)) begin
        r_tx_baud <= '0;
        r_tx_shft <= {1'b1, r_tx_shft[9:1]};
        r_tx_bits <= r_tx_bits + 4'd1;
        if (r_tx_bits == 4'd9) begin
          r_tx_busy <= 1'b0;
          r_tx_done <= 1'b1;
        end
      end else begin
        r_tx_baud <= r_tx_baud + BW'(1);
      end
    end
  end

  // Receiver: samples mid-bit, counting from the synchronised start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_busy <= 1'b0;
      r_rx_baud <= '0;
      r_rx_bits <= '0;
      r_rx_shft <= '0;
      r_rx_rdy  <= 1'b0;
    end else begin
      r_rx_s1 <= RX;
      r_rx_s2 <= r_rx_s1;
      if (clr_rx_rdy) r_rx_rdy <= 1'b0;
      if (!r_rx_busy) begin
        if (!r_rx_s2) begin
          r_rx_busy <= 1'b1;
          r_rx_baud <= BW'(BAUD_DIV / 2 - 1);
          r_rx_bits <= '0;
        end
      end else if (r_rx_baud != '0) begin
        r_rx_baud <= r_rx_baud - BW'(1);
      end else begin
        r_rx_baud <= BW'(BAUD_DIV - 1);
        r_rx_bits <= r_rx_bits + 4'd1;
        if (r_rx_bits >= 4'd1 && r_rx_bits <= 4'd8) r_rx_shft <= {r_rx_s2, r_rx_shft[7:1]};
        if (r_rx_bits == 4'd9) begin
          r_rx_busy <= 1'b0;
          r_rx_rdy  <= 1'b1;
        end
      end
    end
  end

  assign TX      = r_tx_shft[0];
  assign tx_done = r_tx_done;
  assign rx_rdy  = r_rx_rdy;
  assign rx_data = r_rx_shft;

endmodule

module remote_comm #(
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  input  logic        clr_resp_rdy,
  input  logic        RX,
  output logic        TX,
  output logic        busy,
  output logic        cmd_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp,
  output logic        timeout
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, TX_HI, TX_LO, WAIT_RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_cmd_q, w_cmd_q_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_trmt, w_trmt_nxt;
  logic          r_clr_rx_rdy, w_clr_nxt;
  logic          r_cmd_snt, w_cmd_snt_nxt;
  logic          r_resp_rdy, w_resp_rdy_nxt;
  logic [7:0]    r_resp, w_resp_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic          r_busy;
  logic          r_done_d;

  logic          w_tx_done;
  logic          w_rx_rdy;
  logic [7:0]    w_rx_data;
  logic [7:0]    w_tx_data;
  logic          w_done_rise;
  logic          w_rx_fresh;

  UART u_uart (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .trmt       (r_trmt),
    .tx_data    (w_tx_data),
    .tx_done    (w_tx_done),
    .rx_rdy     (w_rx_rdy),
    .clr_rx_rdy (r_clr_rx_rdy),
    .rx_data    (w_rx_data)
  );

  assign w_tx_data   = (r_state == TX_LO) ? r_cmd_q[7:0] : r_cmd_q[15:8];
  assign w_done_rise = w_tx_done & ~r_done_d;
  // rx_rdy stays high during the cycle its clear is in flight; don't act on it twice.
  assign w_rx_fresh  = w_rx_rdy & ~r_clr_rx_rdy;

  always_comb begin
    w_state_nxt    = r_state;
    w_cmd_q_nxt    = r_cmd_q;
    w_cnt_nxt      = r_cnt;
    w_trmt_nxt     = 1'b0;
    w_clr_nxt      = 1'b0;
    w_cmd_snt_nxt  = r_cmd_snt;
    w_resp_rdy_nxt = r_resp_rdy & ~clr_resp_rdy;
    w_resp_nxt     = r_resp;
    w_timeout_nxt  = r_timeout;
    case (r_state)
      IDLE: begin
        if (w_rx_fresh) w_clr_nxt = 1'b1;
        if (snd_cmd) begin
          w_cmd_q_nxt    = cmd;
          w_cmd_snt_nxt  = 1'b0;
          w_resp_rdy_nxt = 1'b0;
          w_timeout_nxt  = 1'b0;
          w_trmt_nxt     = 1'b1;
          w_state_nxt    = TX_HI;
        end
      end
      TX_HI: begin
        if (w_rx_fresh) w_clr_nxt = 1'b1;
        if (w_done_rise) begin
          w_trmt_nxt  = 1'b1;
          w_state_nxt = TX_LO;
        end
      end
      TX_LO: begin
        if (w_rx_fresh) w_clr_nxt = 1'b1;
        if (w_done_rise) begin
          w_cmd_snt_nxt = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_rx_fresh) begin
          w_resp_nxt     = w_rx_data;
          w_resp_rdy_nxt = 1'b1;
          w_clr_nxt      = 1'b1;
          w_state_nxt    = IDLE;
        end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cmd_q      <= '0;
      r_cnt        <= '0;
      r_trmt       <= 1'b0;
      r_clr_rx_rdy <= 1'b0;
      r_cmd_snt    <= 1'b0;
      r_resp_rdy   <= 1'b0;
      r_resp       <= 8'h00;
      r_timeout    <= 1'b0;
      r_busy       <= 1'b0;
      r_done_d     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cmd_q      <= w_cmd_q_nxt;
      r_cnt        <= w_cnt_nxt;
      r_trmt       <= w_trmt_nxt;
      r_clr_rx_rdy <= w_clr_nxt;
      r_cmd_snt    <= w_cmd_snt_nxt;
      r_resp_rdy   <= w_resp_rdy_nxt;
      r_resp       <= w_resp_nxt;
      r_timeout    <= w_timeout_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      r_done_d     <= w_tx_done;
    end
  end

  assign busy     = r_busy;
  assign cmd_snt  = r_cmd_snt;
  assign resp_rdy = r_resp_rdy;
  assign resp     = r_resp;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: a second UART loops the command bytes back and supplies replies.

module tb_remote_comm;

  localparam int TMO = 1000;
  localparam int BIT = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snd_cmd = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        clr_resp_rdy = 1'b0;
  logic        d_rx;
  logic        d_tx;
  logic        busy, cmd_snt, resp_rdy, timeout;
  logic [7:0]  resp;

  logic        b_trmt = 1'b0;
  logic [7:0]  b_tx_data = 8'h00;
  logic        b_tx_done;
  logic        b_rx_rdy;
  logic        b_clr = 1'b0;
  logic [7:0]  b_rx_data;

  int n_cmp = 0;
  int n_fail = 0;
  int rx_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  remote_comm #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .snd_cmd(snd_cmd), .cmd(cmd), .clr_resp_rdy(clr_resp_rdy),
    .RX(d_rx), .TX(d_tx), .busy(busy), .cmd_snt(cmd_snt), .resp_rdy(resp_rdy),
    .resp(resp), .timeout(timeout)
  );

  UART #(.BAUD_DIV(BIT)) u_far (
    .clk(clk), .rst_n(rst_n), .RX(d_tx), .TX(d_rx), .trmt(b_trmt), .tx_data(b_tx_data),
    .tx_done(b_tx_done), .rx_rdy(b_rx_rdy), .clr_rx_rdy(b_clr), .rx_data(b_rx_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Far-end receiver: every byte seen on the wire is popped against the scoreboard.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (b_rx_rdy) begin
        rx_cnt++;
        check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("frame_byte", {24'h0, b_rx_data}, {24'h0, e});
        end
        b_clr = 1'b1;
        @(negedge clk);
        b_clr = 1'b0;
      end
    end
  end

  task automatic send_cmd(input logic [15:0] c);
    @(negedge clk);
    cmd = c;
    snd_cmd = 1'b1;
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
    @(posedge clk); #1;
    check("busy_after_accept", {31'h0, busy}, 32'd1);
    @(negedge clk);
    snd_cmd = 1'b0;
    cmd = ~c;
  endtask

  task automatic far_reply(input logic [7:0] b);
    @(negedge clk);
    b_tx_data = b;
    b_trmt = 1'b1;
    @(negedge clk);
    b_trmt = 1'b0;
  endtask

  task automatic wait_rx(input int target);
    int n = 0;
    while (rx_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rx_count", rx_cnt, target);
  endtask

  task automatic wait_snt();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!cmd_snt && n < 2000);
    check("cmd_snt_set", {31'h0, cmd_snt}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_low", {31'h0, busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    // Reset and idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_tx", {31'h0, d_tx}, 32'd1);
    check("idle_busy", {31'h0, busy}, 32'd0);
    check("idle_flags", {29'h0, cmd_snt, resp_rdy, timeout}, 32'd0);
    check("idle_resp", {24'h0, resp}, 32'h00);

    // 16'h1234 with reply A5
    send_cmd(16'h1234);
    wait_rx(2);
    check("snt_before_done", {31'h0, cmd_snt}, 32'd0);
    wait_snt();
    far_reply(8'hA5);
    wait_idle();
    check("resp_a5", {24'h0, resp}, 32'hA5);
    check("resp_rdy_a5", {31'h0, resp_rdy}, 32'd1);
    check("timeout_a5", {31'h0, timeout}, 32'd0);

    // 16'hFF00 with no reply: timeout exactly TMO cycles after WAIT_RESP entry
    send_cmd(16'hFF00);
    check("resp_rdy_cleared", {31'h0, resp_rdy}, 32'd0);
    wait_snt();
    cyc = 0;
    while (!timeout && cyc < 2 * TMO) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("timeout_latency", cyc, TMO);
    check("timeout_busy", {31'h0, busy}, 32'd0);
    check("timeout_resp_rdy", {31'h0, resp_rdy}, 32'd0);
    check("timeout_resp_kept", {24'h0, resp}, 32'hA5);

    // snd_cmd during TX_HI is ignored
    send_cmd(16'h0102);
    @(negedge clk);
    cmd = 16'hDEAD;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    wait_rx(6);
    wait_idle();
    repeat (15 * BIT) @(negedge clk);
    check("no_third_frame", rx_cnt, 6);
    check("dead_timeout", {31'h0, timeout}, 32'd1);

    // Stray byte in IDLE is discarded
    far_reply(8'h77);
    repeat (15 * BIT) @(negedge clk);
    check("stray_resp_rdy", {31'h0, resp_rdy}, 32'd0);
    check("stray_resp", {24'h0, resp}, 32'hA5);
    check("stray_busy", {31'h0, busy}, 32'd0);
    send_cmd(16'h4321);
    wait_snt();
    far_reply(8'h3C);
    wait_idle();
    check("resp_3c", {24'h0, resp}, 32'h3C);
    check("resp_rdy_3c", {31'h0, resp_rdy}, 32'd1);
    @(negedge clk);
    clr_resp_rdy = 1'b1;
    @(negedge clk);
    clr_resp_rdy = 1'b0;
    check("clr_resp_rdy", {31'h0, resp_rdy}, 32'd0);
    check("clr_resp_kept", {24'h0, resp}, 32'h3C);

    // Reset in the middle of the low-byte frame
    send_cmd(16'h5A5A);
    wait_rx(9);
    repeat (5 * BIT) @(negedge clk);
    check("mid_low_busy", {31'h0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_tx", {31'h0, d_tx}, 32'd1);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_flags", {29'h0, cmd_snt, resp_rdy, timeout}, 32'd0);
    check("rst_resp", {24'h0, resp}, 32'h00);
    check("aborted_low_pending", exp_q.size(), 1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20 * BIT) @(negedge clk);
    check("after_rst_rx_count", rx_cnt, 9);

    send_cmd(16'hBEEF);
    wait_rx(11);
    wait_snt();
    far_reply(8'h5E);
    wait_idle();
    check("resp_5e", {24'h0, resp}, 32'h5E);
    check("resp_rdy_5e", {31'h0, resp_rdy}, 32'd1);
    check("timeout_5e", {31'h0, timeout}, 32'd0);
    repeat (15 * BIT) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("final_rx_count", rx_cnt, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/remote_comm.md
# remote_comm

Host-side command initiator for the serial link. It accepts a 16-bit command, sends it over UART as two bytes (high byte first), then waits for the single-byte response from the far end. The far end is the on-board command receiver. The block instantiates the existing `UART` module (8N1 transmitter plus receiver; bit timing is owned by `UART`) and adds the sequencing FSM, the command holding register, response capture and a response timeout. It sits in test benches and host-side models as the counterpart that drives the DUT's command interface.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 2_000_000: number of clocks to wait in WAIT_RESP before declaring a timeout. The counter width is `$clog2(TIMEOUT_CYC+1)`.

Ports:
- `clk` in 1: system clock. This is the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `snd_cmd` in 1: request to send `cmd`. Sampled only in IDLE.
- `cmd` in 16: command word. Latched on an accepted `snd_cmd`.
- `clr_resp_rdy` in 1: clears `resp_rdy`.
- `RX` in 1: serial input from the far end.
- `TX` out 1: serial output to the far end. Idles high.
- `busy` out 1: high in any state other than IDLE.
- `cmd_snt` out 1: sticky. Set when the low byte's frame completes.
- `resp_rdy` out 1: sticky. Set when a response byte is captured.
- `resp` out 8: last captured response byte.
- `timeout` out 1: sticky. Set when no response arrives within `TIMEOUT_CYC`.

## Operation
- The FSM has four states: IDLE, TX_HI, TX_LO and WAIT_RESP. Reset enters IDLE.
- An internal `done_rise` signal marks the first cycle the UART's `tx_done` is high after being low. This is a registered edge detect, so it works whether `tx_done` is a level or a pulse.
- IDLE:
  - If `snd_cmd` is high: latch `cmd` into `cmd_q`, clear `cmd_snt`, `resp_rdy` and `timeout`, and go to TX_HI.
  - Otherwise stay in IDLE.
- TX_HI:
  - On entry, assert `trmt` for exactly 1 cycle with `tx_data` = `cmd_q[15:8]`.
  - On `done_rise`, go to TX_LO.
- TX_LO:
  - On entry, assert `trmt` for 1 cycle with `tx_data` = `cmd_q[7:0]`.
  - On `done_rise`, set `cmd_snt`, clear the timeout counter and go to WAIT_RESP.
- WAIT_RESP:
  - The timeout counter increments every cycle.
  - If the UART's `rx_rdy` is high: `resp <= rx_data`, set `resp_rdy`, pulse `clr_rx_rdy` for 1 cycle, go to IDLE.
  - Else if the counter equals `TIMEOUT_CYC-1`: set `timeout` and go to IDLE. `resp` is left unchanged.
  - If `rx_rdy` and the timeout occur in the same cycle, the response wins and `timeout` is not set.
- `rx_rdy` seen in IDLE, TX_HI or TX_LO is a stray byte. It is discarded by a 1-cycle `clr_rx_rdy` pulse, and `resp` and `resp_rdy` are untouched.
- `snd_cmd` outside IDLE is ignored, with no queueing and no effect on `cmd_q`.
- If `clr_resp_rdy` and a response capture happen in the same cycle, the set wins and `resp_rdy` ends high.
- `cmd` may change freely after acceptance; only `cmd_q` is transmitted.

## Timing
- Reset values:
  - Outputs: `TX`=1, `busy`=0, `cmd_snt`=0, `resp_rdy`=0, `resp`=8'h00, `timeout`=0.
  - Internal: state=IDLE, `cmd_q`=0, counter=0, `trmt`=0, `clr_rx_rdy`=0.
- All outputs are registered, except `TX`, which comes from `UART`.
- Send latency:
  - `snd_cmd` is sampled high at edge N; `trmt` for the high byte is high during cycle N+1.
  - `busy` goes high at N+1.
- The second `trmt` pulse is issued 1 cycle after the high byte's `done_rise`. There is no gap between bytes beyond the UART stop bit.
- `cmd_snt` rises 1 cycle after the low byte's `done_rise`.
- Response capture:
  - `rx_rdy` is high at edge M in WAIT_RESP.
  - `resp`/`resp_rdy` are valid and `busy` is low from M+1.
- A timeout is flagged exactly `TIMEOUT_CYC` cycles after entering WAIT_RESP.
- Reset mid-operation:
  - `rst_n` low aborts any frame immediately and returns all outputs to their reset values.
  - `UART` is reset by the same `rst_n`.

## Test plan
- Reset, then idle for 100 cycles: `TX`=1, `busy`=0, all flags 0, `resp`=8'h00.
- Loop `TX` back through a second `UART` and check the bytes in order. Then have that bench UART reply 8'hA5. Pulse `snd_cmd` with `cmd`=16'h1234:
  - The bench UART must receive 8'h12 then 8'h34.
  - `cmd_snt` must rise after the second frame.
  - `resp`=8'hA5 and `resp_rdy`=1; `timeout`=0.
- Send `cmd`=16'hFF00 with no reply, using `TIMEOUT_CYC`=1000:
  - `timeout` rises exactly 1000 cycles after WAIT_RESP entry.
  - `resp_rdy`=0 and `busy` returns to 0.
- Pulse `snd_cmd` again with `cmd`=16'hDEAD during TX_HI of a 16'h0102 send: the wire carries only 8'h01, 8'h02, and no third frame is sent.
- Inject a stray reply byte 8'h77 while in IDLE: `resp_rdy` stays 0 and `resp` is unchanged. A following command with reply 8'h3C yields `resp`=8'h3C.
- Assert `rst_n`=0 midway through the low-byte frame: all outputs return to their reset values within the same cycle. After release, a new send of 16'hBEEF completes normally.
